// File: rtl/toggle_rx.sv
// Toggle-signalling receiver: edge-detects a sender's T flip-flop level, counts events,
// queues them behind a valid/ack handshake and runs a stall watchdog. Macro TOGGLE_RX_SYNC_EN adds a 2-flop input synchronizer.
module toggle_rx #(
  parameter int CNT_W   = 8,
  parameter int PEND_W  = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_Q,
  output logic              evt_pulse,
  output logic              evt_valid,
  input  logic              evt_ack,
  output logic [CNT_W-1:0]  evt_count,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic [1:0]        state,
  output logic              stalled
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    STALLED = 2'd2
  } wd_state_t;

  localparam int                 IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0]  IDLE_MAX = IDLE_W'(TIMEOUT);
  localparam logic [PEND_W-1:0]  PEND_MAX = '1;

  logic              s_in;
  logic              s_last;
  logic              accept;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_next;
  wd_state_t         state_q;
  wd_state_t         state_next;

`ifdef TOGGLE_RX_SYNC_EN
  logic sync1;
  logic sync2;

  // Loading the live level at reset keeps a high in_Q from looking like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= in_Q;
      sync2 <= in_Q;
    end else begin
      sync1 <= in_Q;
      sync2 <= sync1;
    end
  end

  assign s_in = sync2;
`else
  assign s_in = in_Q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s_last    <= in_Q;
      evt_pulse <= 1'b0;
    end else begin
      s_last    <= s_in;
      evt_pulse <= s_in ^ s_last;
    end
  end

  assign evt_valid = (pending != '0);
  assign accept    = evt_ack && evt_valid;

  // A pulse and an acceptance in the same cycle cancel, even when saturated.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_count <= '0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (evt_pulse) begin
        evt_count <= evt_count + CNT_W'(1);
      end
      if (evt_pulse && !accept) begin
        if (pending == PEND_MAX) begin
          overflow <= 1'b1;
        end else begin
          pending <= pending + PEND_W'(1);
        end
      end else if (accept && !evt_pulse) begin
        pending <= pending - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
      state_q  <= IDLE;
    end else begin
      idle_cnt <= idle_next;
      state_q  <= state_next;
    end
  end

  // Stall is declared on the edge where the timer lands on TIMEOUT, not one cycle later.
  always_comb begin
    idle_next  = idle_cnt;
    state_next = state_q;
    if (evt_pulse) begin
      idle_next = '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_next = idle_cnt + IDLE_W'(1);
    end
    case (state_q)
      IDLE:    if (evt_pulse) state_next = ACTIVE;
      ACTIVE:  if (!evt_pulse && idle_next == IDLE_MAX) state_next = STALLED;
      STALLED: if (evt_pulse) state_next = ACTIVE;
      default: state_next = IDLE;
    endcase
  end

  assign state   = state_q;
  assign stalled = (state_q == STALLED);

endmodule

// File: tb/tb_toggle_rx.sv
// Scoreboard bench for toggle_rx: expected pulses are queued at stimulus time, while a
// level-history reference model predicts count, pending, overflow and watchdog state.
module tb_toggle_rx;

  localparam int CNT_W    = 8;
  localparam int PEND_W   = 3;
  localparam int TIMEOUT  = 16;
  localparam int PEND_MAX = (1 << PEND_W) - 1;
`ifdef TOGGLE_RX_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_Q;
  logic              evt_ack;
  logic              evt_pulse;
  logic              evt_valid;
  logic [CNT_W-1:0]  evt_count;
  logic [PEND_W-1:0] pending;
  logic              overflow;
  logic [1:0]        state;
  logic              stalled;

  toggle_rx #(.CNT_W(CNT_W), .PEND_W(PEND_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_Q(in_Q),
    .evt_pulse(evt_pulse), .evt_valid(evt_valid), .evt_ack(evt_ack),
    .evt_count(evt_count), .pending(pending), .overflow(overflow),
    .state(state), .stalled(stalled)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int cnt;
  } pulse_exp_t;

  pulse_exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int sb_seq = 0;

  int m_count   = 0;
  int m_pending = 0;
  int m_last    = 0;
  bit m_overflow = 0;
  bit m_pulse    = 0;
  bit m_seen     = 0;
  bit m_acc;
  bit h[4];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Drives one cycle of stimulus; each toggle immediately books its expected pulse.
  task automatic applyStimulus(input bit toggle, input bit ack);
    @(negedge clk);
    evt_ack = ack;
    if (toggle) begin
      in_Q = ~in_Q;
      sb_q.push_back('{cyc + 1 + D, sb_seq % (1 << CNT_W)});
      sb_seq++;
    end
  endtask

  task automatic applyReset(input int n, input bit level);
    @(negedge clk);
    reset   = 1'b1;
    evt_ack = 1'b0;
    in_Q    = level;
    repeat (n) @(negedge clk);
    reset  = 1'b0;
    sb_seq = 0;
  endtask

  // Reference model: pulses come from sampled-level history, the rest from event arithmetic.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_count    = 0;
      m_pending  = 0;
      m_overflow = 0;
      m_seen     = 0;
      m_pulse    = 0;
      for (int i = 0; i < 4; i++) h[i] = in_Q;
    end else begin
      m_acc = evt_ack && (m_pending > 0);
      if (m_pulse) begin
        m_count = (m_count + 1) % (1 << CNT_W);
        m_seen  = 1;
        m_last  = cyc - 1;
      end
      if (m_pulse && !m_acc) begin
        if (m_pending == PEND_MAX) m_overflow = 1;
        else m_pending++;
      end else if (m_acc && !m_pulse) begin
        m_pending--;
      end
      for (int i = 3; i > 0; i--) h[i] = h[i-1];
      h[0] = in_Q;
      m_pulse = (h[D] != h[D+1]);
    end
  end

  // Monitor: compares every cycle and retires scoreboard entries when a pulse shows up.
  always @(posedge clk) begin
    int exp_state;
    pulse_exp_t e;
    #2;
    if (!m_seen) exp_state = 0;
    else if (cyc - m_last >= TIMEOUT + 1) exp_state = 2;
    else exp_state = 1;
    checkOutput("evt_count", int'(evt_count), m_count);
    checkOutput("pending", int'(pending), m_pending);
    checkOutput("evt_valid", int'(evt_valid), int'(m_pending != 0));
    checkOutput("overflow", int'(overflow), int'(m_overflow));
    checkOutput("state", int'(state), exp_state);
    checkOutput("stalled", int'(stalled), int'(exp_state == 2));
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL pulse_missing at cycle %0d: got none expected pulse at cycle %0d", cyc, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end
    if (evt_pulse) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pulse_spurious at cycle %0d: got pulse expected none", cyc);
      end else begin
        e = sb_q.pop_front();
        checkOutput("pulse_cycle", cyc, e.cyc);
        checkOutput("pulse_count", int'(evt_count), e.cnt);
      end
    end
  end

  initial begin
    int tp;
    int ap;
    reset   = 1'b1;
    in_Q    = 1'b1;
    evt_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) applyStimulus(0, 0);

    repeat (3) begin
      applyStimulus(1, 0);
      repeat (4) applyStimulus(0, 0);
    end
    repeat (5) applyStimulus(0, 1);
    repeat (2) applyStimulus(0, 0);

    repeat (9) applyStimulus(1, 0);
    repeat (D + 3) applyStimulus(0, 0);
    applyStimulus(1, 0);
    repeat (D) applyStimulus(0, 0);
    applyStimulus(0, 1);
    applyStimulus(0, 0);

    repeat (TIMEOUT + 6) applyStimulus(0, 0);
    applyStimulus(1, 0);
    repeat (D + 4) applyStimulus(0, 0);

    repeat (2) applyStimulus(0, 1);
    applyStimulus(0, 0);
    applyReset(1, 1'b1);
    repeat (4) applyStimulus(0, 0);

    tp = 1;
    ap = 1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) begin
        tp = $urandom_range(0, 4);
        ap = $urandom_range(0, 4);
      end
      if ($urandom_range(0, 299) == 0) begin
        repeat (D + 3) applyStimulus(0, 0);
        applyReset($urandom_range(1, 3), 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 199) == 0) begin
        repeat (TIMEOUT + $urandom_range(0, 4)) applyStimulus(0, 0);
      end else begin
        applyStimulus($urandom_range(0, 3) < tp, $urandom_range(0, 3) < ap);
      end
    end

    repeat (D + 5) applyStimulus(0, 0);
    checkOutput("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
